// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic_pkg
// Description : Shared definitions for the CIC channel merge path: channel
//               limits, overflow counter type and the round-robin search
//               helper used by round_robin_picker.
// Revision    : 1.0 - initial release
// ============================================================================
package cic_pkg;

    localparam int MaxChannels       = 16;
    localparam int MaxChannelBits    = 4;
    localparam int OverflowCountBits = 16;

    typedef logic [OverflowCountBits-1:0] overflow_count_t;

    // Returns {found, index}: the first set request at or after last+1,
    // wrapping modulo num. Only the lowest num request bits are considered.
    function automatic logic [MaxChannelBits:0] rr_next_index(
        input logic [MaxChannels-1:0]    req,
        input logic [MaxChannelBits-1:0] last,
        input int unsigned               num
    );
        logic                      found;
        logic [MaxChannelBits-1:0] idx;
        logic [MaxChannelBits-1:0] cand4;
        int unsigned               cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= MaxChannels; k++) begin
            cand  = (32'(last) + k) % num;
            cand4 = cand[MaxChannelBits-1:0];
            if (k <= num && !found && req[cand4]) begin
                found = 1'b1;
                idx   = cand4;
            end
        end
        return {found, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_robin_picker.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_picker
// Description : Combinational round-robin selector. Searches the request
//               vector starting one above last_grant, wrapping around.
// Ports       : req         - request vector (NumReq bits)
//               last_grant  - index granted most recently
//               grant_valid - at least one request present
//               grant_idx   - selected request index
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_picker
    import cic_pkg::*;
#(
    parameter int NumReq  = 4,
    parameter int IdxBits = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]  req,
    input  logic [IdxBits-1:0] last_grant,
    output logic               grant_valid,
    output logic [IdxBits-1:0] grant_idx
);

    logic [MaxChannels-1:0]    w_req;
    logic [MaxChannelBits-1:0] w_last;
    logic [MaxChannelBits:0]   w_result;

    always_comb begin
        w_req               = '0;
        w_req[NumReq-1:0]   = req;
        w_last              = MaxChannelBits'(last_grant);
        w_result            = rr_next_index(w_req, w_last, NumReq);
        grant_valid         = w_result[MaxChannelBits];
        grant_idx           = IdxBits'(w_result[MaxChannelBits-1:0]);
    end

endmodule
`default_nettype wire

// File: rtl/cic_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cic_channel_arbiter
// Description : Merges NumChannels CIC/compensator outputs into one tagged
//               valid/ready stream. One holding word per channel, round-robin
//               drain into a registered output stage, sticky drop flags.
// Ports       : clk, rst_n (async, active low)
//               in[N][W], in_valid[N], in_ready[N]  - per-channel inputs
//               out, out_channel, out_valid, out_ready - merged output
//               overflow[N], overflow_clear           - drop reporting
//               overflow_count[N] (16b each)          - only with macro
// Options     : CIC_ARB_OVERFLOW_COUNT_EN adds saturating drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_channel_arbiter
    import cic_pkg::*;
#(
    parameter int NumChannels    = 4,
    parameter int DataLengthBits = 36,
    parameter int ChannelBits    = $clog2(NumChannels)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NumChannels-1:0][DataLengthBits-1:0] in,
    input  logic [NumChannels-1:0]                    in_valid,
    output logic [NumChannels-1:0]                    in_ready,
    output logic [DataLengthBits-1:0]                 out,
    output logic [ChannelBits-1:0]                    out_channel,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [NumChannels-1:0]                    overflow,
    input  logic                                      overflow_clear
`ifdef CIC_ARB_OVERFLOW_COUNT_EN
    ,
    output overflow_count_t [NumChannels-1:0]         overflow_count
`endif
);

    logic [NumChannels-1:0][DataLengthBits-1:0] r_buf_data;
    logic [NumChannels-1:0]                     r_buf_full;
    logic [DataLengthBits-1:0]                  r_out;
    logic [ChannelBits-1:0]                     r_out_channel;
    logic                                       r_out_valid;
    logic [NumChannels-1:0]                     r_overflow;
    logic [ChannelBits-1:0]                     r_last_grant;
`ifdef CIC_ARB_OVERFLOW_COUNT_EN
    overflow_count_t [NumChannels-1:0]          r_ovf_count;
`endif

    logic                   w_free;
    logic                   w_grant_valid;
    logic [ChannelBits-1:0] w_grant_idx;
    logic                   w_grant;
    logic [NumChannels-1:0] w_take;
    logic [NumChannels-1:0] w_accept;
    logic [NumChannels-1:0] w_drop;

    round_robin_picker #(
        .NumReq  (NumChannels),
        .IdxBits (ChannelBits)
    ) u_picker (
        .req         (r_buf_full),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // A channel being drained this cycle can accept a new word in the same
    // cycle: the old word moves to the output, the new one takes its place.
    always_comb begin
        w_free   = !r_out_valid || out_ready;
        w_grant  = w_free && w_grant_valid;
        w_take   = '0;
        w_accept = '0;
        w_drop   = '0;
        for (int i = 0; i < NumChannels; i++) begin
            w_take[i]   = w_grant && (w_grant_idx == ChannelBits'(i));
            w_accept[i] = in_valid[i] && (!r_buf_full[i] || w_take[i]);
            w_drop[i]   = in_valid[i] && r_buf_full[i] && !w_take[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_data    <= '0;
            r_buf_full    <= '0;
            r_out         <= '0;
            r_out_channel <= '0;
            r_out_valid   <= 1'b0;
            r_overflow    <= '0;
            r_last_grant  <= ChannelBits'(NumChannels - 1);
`ifdef CIC_ARB_OVERFLOW_COUNT_EN
            r_ovf_count   <= '0;
`endif
        end else begin
            if (w_grant) begin
                r_out         <= r_buf_data[w_grant_idx];
                r_out_channel <= w_grant_idx;
                r_out_valid   <= 1'b1;
                r_last_grant  <= w_grant_idx;
            end else if (w_free) begin
                r_out_valid   <= 1'b0;
            end

            for (int i = 0; i < NumChannels; i++) begin
                if (w_accept[i]) begin
                    r_buf_data[i] <= in[i];
                    r_buf_full[i] <= 1'b1;
                end else if (w_take[i]) begin
                    r_buf_full[i] <= 1'b0;
                end

                // A drop in the clearing cycle must still be reported.
                if (w_drop[i]) begin
                    r_overflow[i] <= 1'b1;
                end else if (overflow_clear) begin
                    r_overflow[i] <= 1'b0;
                end

`ifdef CIC_ARB_OVERFLOW_COUNT_EN
                if (overflow_clear) begin
                    r_ovf_count[i] <= w_drop[i] ? overflow_count_t'(1) : '0;
                end else if (w_drop[i] && (r_ovf_count[i] != '1)) begin
                    r_ovf_count[i] <= r_ovf_count[i] + overflow_count_t'(1);
                end
`endif
            end
        end
    end

    assign in_ready    = ~r_buf_full;
    assign out         = r_out;
    assign out_channel = r_out_channel;
    assign out_valid   = r_out_valid;
    assign overflow    = r_overflow;
`ifdef CIC_ARB_OVERFLOW_COUNT_EN
    assign overflow_count = r_ovf_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cic_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_channel_arbiter
// Description : Self-checking bench for cic_channel_arbiter (4 channels,
//               36-bit samples) against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_channel_arbiter;

    localparam int N  = 4;
    localparam int W  = 36;
    localparam int CB = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0][W-1:0] in_d;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [W-1:0]        out_d;
    logic [CB-1:0]       out_channel;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        overflow;
    logic                overflow_clear;
`ifdef CIC_ARB_OVERFLOW_COUNT_EN
    logic [N-1:0][15:0]  overflow_count;
`endif

    always #5 clk = ~clk;

    cic_channel_arbiter #(
        .NumChannels    (N),
        .DataLengthBits (W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in             (in_d),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out            (out_d),
        .out_channel    (out_channel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
`ifdef CIC_ARB_OVERFLOW_COUNT_EN
        ,
        .overflow_count (overflow_count)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [W-1:0] m_data [N];
    bit           m_full [N];
    logic [W-1:0] m_out;
    int           m_ch;
    bit           m_valid;
    int           m_last;
    bit           m_ovf  [N];
    int           m_cnt  [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0; m_data[i] = '0; m_ovf[i] = 1'b0; m_cnt[i] = 0;
        end
        m_out = '0; m_ch = 0; m_valid = 1'b0; m_last = N - 1;
    endtask

    // One clock of the arbiter as described by its rules, using the
    // inputs currently applied.
    task automatic model_step();
        int           g;
        bit           free;
        logic [W-1:0] nd [N];
        bit           nf [N];
        free = !m_valid || out_ready;
        g = -1;
        if (free) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (g < 0 && m_full[j]) g = j;
            end
        end
        if (g >= 0) begin
            m_out = m_data[g]; m_ch = g; m_valid = 1'b1; m_last = g;
        end else if (free) begin
            m_valid = 1'b0;
        end
        nd = m_data;
        nf = m_full;
        if (g >= 0) nf[g] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (overflow_clear) begin
                m_ovf[i] = 1'b0; m_cnt[i] = 0;
            end
            if (in_valid[i]) begin
                if (!m_full[i] || g == i) begin
                    nd[i] = in_d[i]; nf[i] = 1'b1;
                end else begin
                    m_ovf[i] = 1'b1;
                    if (m_cnt[i] < 65535) m_cnt[i]++;
                end
            end
        end
        m_data = nd;
        m_full = nf;
    endtask

    task automatic compare_all();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_ovf;
        for (int i = 0; i < N; i++) begin
            exp_ready[i] = !m_full[i];
            exp_ovf[i]   = m_ovf[i];
        end
        check("out_valid",   64'(out_valid),   64'(m_valid));
        check("out",         64'(out_d),       64'(m_out));
        check("out_channel", 64'(out_channel), 64'(m_ch));
        check("in_ready",    64'(in_ready),    64'(exp_ready));
        check("overflow",    64'(overflow),    64'(exp_ovf));
`ifdef CIC_ARB_OVERFLOW_COUNT_EN
        for (int i = 0; i < N; i++)
            check("overflow_count", 64'(overflow_count[i]), 64'(m_cnt[i]));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    logic [63:0] rnd;
    logic [W-1:0] word_a, word_b, word_c;

    initial begin
        rst_n = 1'b0; in_d = '0; in_valid = '0; out_ready = 1'b1; overflow_clear = 1'b0;
        model_reset();
        #12;
        check("rst_out_valid", 64'(out_valid),   64'(0));
        check("rst_out",       64'(out_d),       64'(0));
        check("rst_channel",   64'(out_channel), 64'(0));
        check("rst_overflow",  64'(overflow),    64'(0));
        check("rst_in_ready",  64'(in_ready),    64'hF);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All four channels at once drain 0..3 in order
        for (int i = 0; i < N; i++) in_d[i] = W'((i + 1) * 10);
        in_valid = 4'hF;
        tick();
        in_valid = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            check("burst_out", 64'(out_d),       64'((k + 1) * 10));
            check("burst_ch",  64'(out_channel), 64'(k));
        end
        tick();
        check("burst_end", 64'(out_valid), 64'(0));

        // Single word latency: visible two edges after being sampled
        in_d[2] = -36'sd5; in_valid = 4'b0100;
        tick();
        check("lat_e0", 64'(out_valid), 64'(0));
        in_valid = '0;
        tick();
        check("lat_valid", 64'(out_valid),   64'(1));
        check("lat_out",   64'(out_d),       64'h0000000FFFFFFFFB);
        check("lat_ch",    64'(out_channel), 64'(2));
        tick();
        check("lat_pulse", 64'(out_valid), 64'(0));

        // Backpressure on channel 1
        word_a = 36'h123456789; word_b = 36'hABCDEF012; word_c = 36'h0FEDCBA98;
        in_d[1] = word_a; in_valid = 4'b0010;
        tick();
        in_d[1] = word_b; out_ready = 1'b0;
        tick();
        in_valid = '0;
        repeat (5) begin
            tick();
            check("bp_hold", 64'(out_d), 64'(word_a));
        end
        in_d[1] = word_c; in_valid = 4'b0010;
        tick();
        check("bp_ovf",   64'(overflow[1]), 64'(1));
        check("bp_ready", 64'(in_ready[1]), 64'(0));
        in_valid = '0; overflow_clear = 1'b1;
        tick();
        check("bp_clear", 64'(overflow[1]), 64'(0));
        overflow_clear = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_next", 64'(out_d), 64'(word_b));
        tick();

        // Grant and write on the same channel in the same cycle
        in_d[0] = word_a; in_valid = 4'b0001;
        tick();
        in_d[0] = word_b;
        tick();
        check("gw_first", 64'(out_d),       64'(word_a));
        check("gw_noovf", 64'(overflow[0]), 64'(0));
        in_valid = '0;
        tick();
        check("gw_second", 64'(out_d), 64'(word_b));
        tick();

        // Reset in the middle of traffic
        out_ready = 1'b0;
        in_d[0] = 36'h111; in_d[1] = 36'h222; in_d[2] = 36'h333; in_valid = 4'b0111;
        tick();
        tick();
        in_valid = '0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("mrst_valid",  64'(out_valid),   64'(0));
        check("mrst_out",    64'(out_d),       64'(0));
        check("mrst_ch",     64'(out_channel), 64'(0));
        check("mrst_ready",  64'(in_ready),    64'hF);
        check("mrst_ovf",    64'(overflow),    64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            tick();
            check("mrst_nostale", 64'(out_valid), 64'(0));
        end
        in_valid = 4'b0101;
        tick();
        in_valid = '0;
        tick();
        check("mrst_first", 64'(out_channel), 64'(0));

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                rnd = {$urandom(), $urandom()};
                in_d[i] = rnd[W-1:0];
            end
            in_valid       = N'($urandom());
            out_ready      = ($urandom_range(0, 3) != 0);
            overflow_clear = ($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid = '0; overflow_clear = 1'b0; out_ready = 1'b1;
        repeat (6) tick();

`ifdef CIC_ARB_OVERFLOW_COUNT_EN
        // Saturating drop counter on channel 3
        out_ready = 1'b0; overflow_clear = 1'b1; in_valid = 4'b1000;
        tick();
        overflow_clear = 1'b0;
        repeat (65600) tick();
        check("cnt_sat", 64'(overflow_count[3]), 64'hFFFF);
        overflow_clear = 1'b1;
        tick();
        check("cnt_clr_drop", 64'(overflow_count[3]), 64'(1));
        overflow_clear = 1'b0; in_valid = '0; out_ready = 1'b1;
        repeat (6) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
